text_writer: RTL and testbench



---
 rtl/text_pkg.sv | 36 +++
 rtl/text_writer_if.sv | 26 ++
 rtl/text_msg_rom.sv | 32 +++
 rtl/text_writer.sv | 101 ++++++++++
 tb/tb_text_writer.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text writer: message entry layout, message
// indices and the message ROM contents.
package text_pkg;

  localparam int DEF_GLYPH_W = 6;
  localparam int ROM_ADDR_W  = 16;
  localparam int ROM_MAX_LEN = 16;
  localparam int ROM_DEPTH   = 4;
  localparam int ROM_LEN_W   = $clog2(ROM_MAX_LEN + 1);

  typedef struct packed {
    logic [ROM_ADDR_W-1:0]                     base;
    logic [ROM_LEN_W-1:0]                      len;
    logic [0:ROM_MAX_LEN-1][DEF_GLYPH_W-1:0]   glyph;
  } msg_entry_t;

  localparam int MSG_GAME_OVER = 0;
  localparam int MSG_SCORE     = 1;
  localparam int MSG_EMPTY     = 2;
  localparam int MSG_WRAP      = 3;

  localparam logic [15:0] BLANK_WORD = 16'h0000;

  // Glyph 0 of each string sits in the leftmost slot of the concatenation.
  localparam msg_entry_t MSG_ROM [ROM_DEPTH] = '{
    '{base: 16'd55,   len: 5'd8,
      glyph: {6'h1C, 6'h17, 6'h17, 6'h25, 6'h0B, 6'h0A, 6'h0D, 6'h23, {8{6'h00}}}},
    '{base: 16'd100,  len: 5'd5,
      glyph: {6'h11, 6'h0C, 6'h2A, 6'h3F, 6'h00, {11{6'h00}}}},
    '{base: 16'd300,  len: 5'd0,
      glyph: {16{6'h00}}},
    '{base: 16'hFFFE, len: 5'd4,
      glyph: {6'h10, 6'h20, 6'h30, 6'h05, {12{6'h00}}}}
  };

endpackage

// File: rtl/text_writer_if.sv
// Request/status and RAM write-port bundle between a controller and the
// text writer.
interface text_writer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SEL_W  = 2
);
  logic              start;
  logic [SEL_W-1:0]  msg_sel;
  logic              erase;
  logic              busy;
  logic              done;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dina;

  modport master (
    output start, msg_sel, erase,
    input  busy, done, we, addr, dina
  );

  modport slave (
    input  start, msg_sel, erase,
    output busy, done, we, addr, dina
  );
endinterface

// File: rtl/text_msg_rom.sv
// Combinational message ROM lookup; selections at or beyond NUM_MSG read
// back as an empty message.
module text_msg_rom
  import text_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int NUM_MSG = 4,
  parameter int SEL_W   = 2,
  parameter int LEN_W   = 5
) (
  input  logic [SEL_W-1:0]       msg_sel,
  input  logic [LEN_W-1:0]       idx,
  output logic [ADDR_W-1:0]      base,
  output logic [LEN_W-1:0]       len,
  output logic [DEF_GLYPH_W-1:0] glyph
);

  localparam int GIDX_W = $clog2(ROM_MAX_LEN);

  msg_entry_t entry;

  always_comb begin
    entry = '0;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      if (i < NUM_MSG && int'(msg_sel) == i) entry = MSG_ROM[i];
    end
    base  = ADDR_W'(entry.base);
    len   = LEN_W'(entry.len);
    glyph = entry.glyph[idx[GIDX_W-1:0]];
  end

endmodule

// File: rtl/text_writer.sv
// Streams one ROM message (or its blank span) into the text RAM, one word
// per clock, then pulses done.
module text_writer
  import text_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int NUM_MSG = 4,
  parameter int MAX_LEN = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  text_writer_if.slave bus
);

  localparam int SEL_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t            state;
  logic [SEL_W-1:0]  sel_q;
  logic              erase_q;
  logic [LEN_W-1:0]  idx;

  logic [SEL_W-1:0]       rom_sel;
  logic [ADDR_W-1:0]      rom_base;
  logic [LEN_W-1:0]       rom_len;
  logic [DEF_GLYPH_W-1:0] rom_glyph;

  function automatic logic [DATA_W-1:0] glyph_word(input logic [DEF_GLYPH_W-1:0] g);
    glyph_word = '0;
    glyph_word[DATA_W-1]    = 1'b1;
    glyph_word[GLYPH_W-1:0] = GLYPH_W'(g);
  endfunction

  // While idle the ROM looks at the live request so acceptance needs no extra cycle.
  assign rom_sel  = (state == S_IDLE) ? bus.msg_sel : sel_q;
  assign bus.busy = (state != S_IDLE);

  text_msg_rom #(
    .ADDR_W  (ADDR_W),
    .NUM_MSG (NUM_MSG),
    .SEL_W   (SEL_W),
    .LEN_W   (LEN_W)
  ) u_rom (
    .msg_sel (rom_sel),
    .idx     (idx),
    .base    (rom_base),
    .len     (rom_len),
    .glyph   (rom_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sel_q    <= '0;
      erase_q  <= 1'b0;
      idx      <= '0;
      bus.we   <= 1'b0;
      bus.done <= 1'b0;
      bus.addr <= '0;
      bus.dina <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.we   <= 1'b0;
          bus.done <= 1'b0;
          if (bus.start) begin
            sel_q   <= bus.msg_sel;
            erase_q <= bus.erase;
            idx     <= '0;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          // idx reaching len means the final word went out on the previous edge;
          // an empty or illegal message arrives here with len 0 and writes nothing.
          if (idx == rom_len) begin
            bus.we   <= 1'b0;
            bus.done <= 1'b1;
            state    <= S_DONE;
          end else begin
            bus.we   <= 1'b1;
            bus.addr <= rom_base + ADDR_W'(idx);
            bus.dina <= erase_q ? DATA_W'(BLANK_WORD) : glyph_word(rom_glyph);
            idx      <= idx + 1'b1;
          end
        end
        S_DONE: begin
          bus.we   <= 1'b0;
          bus.done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: directed and randomized requests on a 4-message and a
// 3-message instance, checked against a table-driven write-list model.
module tb_text_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  text_writer_if #(.ADDR_W(16), .DATA_W(16), .SEL_W(2)) if_a ();
  text_writer_if #(.ADDR_W(16), .DATA_W(16), .SEL_W(2)) if_b ();

  text_writer #(.NUM_MSG(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  text_writer #(.NUM_MSG(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  int total = 0;
  int bad   = 0;

  // Reference message table: base, length, glyph string.
  logic [15:0] m_base  [4] = '{16'd55, 16'd100, 16'd300, 16'hFFFE};
  int          m_len   [4] = '{8, 5, 0, 4};
  logic [5:0]  m_glyph [4][8] = '{
    '{6'h1C, 6'h17, 6'h17, 6'h25, 6'h0B, 6'h0A, 6'h0D, 6'h23},
    '{6'h11, 6'h0C, 6'h2A, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00},
    '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00},
    '{6'h10, 6'h20, 6'h30, 6'h05, 6'h00, 6'h00, 6'h00, 6'h00}
  };

  function automatic int exp_len(input int sel, input bit on_b);
    if (on_b && sel >= 3) return 0;
    return m_len[sel];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit on_b, input logic s, input logic [1:0] sel, input logic er);
    if (on_b) begin
      if_b.start = s; if_b.msg_sel = sel; if_b.erase = er;
    end else begin
      if_a.start = s; if_a.msg_sel = sel; if_a.erase = er;
    end
  endtask

  task automatic sample(input bit on_b, output logic we, output logic busy, output logic done,
                        output logic [15:0] addr, output logic [15:0] dina);
    if (on_b) begin
      we = if_b.we; busy = if_b.busy; done = if_b.done; addr = if_b.addr; dina = if_b.dina;
    end else begin
      we = if_a.we; busy = if_a.busy; done = if_a.done; addr = if_a.addr; dina = if_a.dina;
    end
  endtask

  // noise: 0 = quiet, 1 = random starts while busy, 2 = starts at N+3 and in the done cycle
  task automatic do_req(input bit on_b, input int sel, input logic er, input int noise);
    int n;
    logic we, busy, done;
    logic [15:0] addr, dina, exp_dina;
    n = exp_len(sel, on_b);
    @(negedge clk);
    drive(on_b, 1'b1, 2'(sel), er);
    @(posedge clk); #1;
    sample(on_b, we, busy, done, addr, dina);
    chk("busy_at_accept", 32'(busy), 32'd1);
    chk("we_at_accept", 32'(we), 32'd0);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (noise == 1)
        drive(on_b, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else if (noise == 2 && (k == 3 || k == n + 2))
        drive(on_b, 1'b1, 2'd1, 1'b0);
      else
        drive(on_b, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      sample(on_b, we, busy, done, addr, dina);
      chk("we", 32'(we), 32'(k <= n));
      chk("done", 32'(done), 32'(k == n + 1));
      chk("busy", 32'(busy), 32'(k <= n + 1));
      if (k <= n) begin
        exp_dina = er ? 16'h0000 : (16'h8000 | 16'(m_glyph[sel][k-1]));
        chk("addr", 32'(addr), 32'(16'(m_base[sel] + 16'(k - 1))));
        chk("dina", 32'(dina), 32'(exp_dina));
      end else if (n > 0) begin
        chk("addr_hold", 32'(addr), 32'(16'(m_base[sel] + 16'(n - 1))));
      end
    end
    @(negedge clk);
    drive(on_b, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    logic we, busy, done;
    logic [15:0] addr, dina;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    #12;
    for (int d = 0; d < 2; d++) begin
      sample(d[0], we, busy, done, addr, dina);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_dina", 32'(dina), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 0, 1'b0, 2);   // draw with ignored starts
    do_req(1'b0, 1, 1'b0, 0);   // accepted right after done
    do_req(1'b0, 0, 1'b1, 0);   // erase
    do_req(1'b0, 2, 1'b0, 0);   // empty message
    do_req(1'b0, 3, 1'b0, 1);   // address wrap
    do_req(1'b1, 3, 1'b0, 0);   // illegal selection
    do_req(1'b1, 1, 1'b1, 0);

    // Reset in the middle of a transfer
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    sample(1'b0, we, busy, done, addr, dina);
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_dina", 32'(dina), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 0, 1'b0, 0);

    for (int r = 0; r < 14; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
